// File: rtl/usb_rx_bit_sequencer.sv
// USB RX bit sequencer: recovers bit timing from the synchronized D+/D- pair,
// NRZI-decodes, drops stuff bits and flags end-of-packet or receive errors.
module usb_rx_bit_sequencer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LEN    = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  output logic shift_enable,
  output logic d_orig,
  output logic eop,
  output logic rx_err,
  output logic idle
);

  localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int ONES_W = (STUFF_LEN > 0) ? $clog2(STUFF_LEN + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ONES_W-1:0] ONES_MAX   = ONES_W'(STUFF_LEN);
  localparam logic [ONES_W-1:0] ONES_ONE   = ONES_W'(1);

  // ERR is split in two so the exit needs an SE0 followed by a J.
  typedef enum logic [2:0] {
    IDLE,
    RUN,
    EOP_WAIT,
    ERR_SE0,
    ERR_J
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  counter, counter_nxt, counter_inc;
  logic [ONES_W-1:0] ones_cnt, ones_nxt;
  logic              prev_line, prev_line_nxt;
  logic              prev_dp;
  logic              shift_nxt, d_orig_nxt, eop_nxt, rx_err_nxt, idle_nxt;
  logic              bit_val;

  logic line_j, line_k, line_se0, line_se1, transition;

  assign line_j     =  d_plus_sync & ~d_minus_sync;
  assign line_k     = ~d_plus_sync &  d_minus_sync;
  assign line_se0   = ~d_plus_sync & ~d_minus_sync;
  assign line_se1   =  d_plus_sync &  d_minus_sync;
  assign transition =  d_plus_sync ^ prev_dp;

  assign counter_inc = (counter == CNT_LAST) ? '0 : counter + CNT_ONE;

  always_comb begin
    state_nxt     = state;
    counter_nxt   = counter;
    ones_nxt      = ones_cnt;
    prev_line_nxt = prev_line;
    shift_nxt     = 1'b0;
    d_orig_nxt    = d_orig;
    eop_nxt       = 1'b0;
    rx_err_nxt    = 1'b0;
    bit_val       = 1'b1;

    if (!enable) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
      ones_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          counter_nxt = '0;
          if (line_k) begin
            counter_nxt   = CNT_ONE;
            prev_line_nxt = 1'b1;
            ones_nxt      = '0;
            state_nxt     = RUN;
          end
        end

        RUN: begin
          // A line edge re-centres the bit window; its own cycle is count 0.
          counter_nxt = transition ? CNT_ONE : counter_inc;
          if (!transition && (counter == CNT_SAMPLE)) begin
            if (line_se0) begin
              state_nxt = EOP_WAIT;
            end else if (line_se1) begin
              rx_err_nxt = 1'b1;
              state_nxt  = ERR_SE0;
            end else begin
              bit_val       = (d_plus_sync == prev_line);
              prev_line_nxt = d_plus_sync;
              if (ones_cnt == ONES_MAX) begin
                if (bit_val) begin
                  rx_err_nxt = 1'b1;
                  state_nxt  = ERR_SE0;
                end else begin
                  ones_nxt = '0;
                end
              end else begin
                shift_nxt  = 1'b1;
                d_orig_nxt = bit_val;
                ones_nxt   = bit_val ? ones_cnt + ONES_ONE : '0;
              end
            end
          end
        end

        EOP_WAIT: begin
          if (line_j) begin
            eop_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end

        ERR_SE0: begin
          if (line_se0) state_nxt = ERR_J;
        end

        ERR_J: begin
          if (line_j) state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end

    idle_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      counter      <= '0;
      ones_cnt     <= '0;
      prev_line    <= 1'b1;
      prev_dp      <= 1'b1;
      shift_enable <= 1'b0;
      d_orig       <= 1'b1;
      eop          <= 1'b0;
      rx_err       <= 1'b0;
      idle         <= 1'b1;
    end else begin
      state        <= state_nxt;
      counter      <= counter_nxt;
      ones_cnt     <= ones_nxt;
      prev_line    <= prev_line_nxt;
      prev_dp      <= d_plus_sync;
      shift_enable <= shift_nxt;
      d_orig       <= d_orig_nxt;
      eop          <= eop_nxt;
      rx_err       <= rx_err_nxt;
      idle         <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_sequencer.sv
// Directed bench for usb_rx_bit_sequencer: SYNC, stuffing, EOP, jitter,
// enable drop and reset behaviour with hand-computed expected strobes.
module tb_usb_rx_bit_sequencer;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst;
  logic enable;
  logic d_plus_sync;
  logic d_minus_sync;
  logic shift_enable;
  logic d_orig;
  logic eop;
  logic rx_err;
  logic idle;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic strobe_q[$];
  int   strobe_cyc[$];
  int   eop_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;

  usb_rx_bit_sequencer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .d_plus_sync  (d_plus_sync),
    .d_minus_sync (d_minus_sync),
    .shift_enable (shift_enable),
    .d_orig       (d_orig),
    .eop          (eop),
    .rx_err       (rx_err),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobes and pulses are logged mid-cycle so scenarios can check totals later.
  always @(negedge clk) begin
    if (shift_enable === 1'b1) begin
      strobe_q.push_back(d_orig);
      strobe_cyc.push_back(cyc);
    end
    if (eop === 1'b1) eop_cnt++;
    if (rx_err === 1'b1) err_cnt++;
    if (eop === 1'b1 && rx_err === 1'b1) both_cnt++;
  end

  task automatic clear_mon();
    strobe_q.delete();
    strobe_cyc.delete();
    eop_cnt = 0;
    err_cnt = 0;
  endtask

  // Holds a line state for n rising edges; returns 1 time unit after the last edge.
  task automatic drive(input logic [1:0] s, input int n);
    {d_plus_sync, d_minus_sync} = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sync(input int pa, input int pb);
    logic [1:0] syms [8];
    syms = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};
    for (int i = 0; i < 8; i++) drive(syms[i], (i % 2 == 0) ? pa : pb);
  endtask

  task automatic test_reset();
    clear_mon();
    n_rst  = 1'b0;
    enable = 1'b1;
    drive(LK, 1);
    drive(LJ, 1);
    drive(LK, 1);
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL reset_idle: got %b, expected 1", idle); end
    n_vec++; if (shift_enable !== 1'b0) begin n_err++; $display("[TB] FAIL reset_shift: got %b, expected 0", shift_enable); end
    n_vec++; if (eop !== 1'b0) begin n_err++; $display("[TB] FAIL reset_eop: got %b, expected 0", eop); end
    n_vec++; if (rx_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rx_err: got %b, expected 0", rx_err); end
    n_vec++; if (d_orig !== 1'b1) begin n_err++; $display("[TB] FAIL reset_d_orig: got %b, expected 1", d_orig); end

    n_rst = 1'b1;
    drive(LJ, 4);
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL idle_on_j: got %b, expected 1", idle); end

    drive(LK, 1);
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("[TB] FAIL start_on_k: got %b, expected 0", idle); end
    #1 n_rst = 1'b0;
    #3 n_rst = 1'b1;
    #1;
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("[TB] FAIL reset_glitch: idle %b, expected 0", idle); end
    @(posedge clk);
    #1;

    n_rst = 1'b0;
    drive(LK, 1);
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL reset_mid_packet_idle: got %b, expected 1", idle); end
    n_rst = 1'b1;
    drive(LJ, 16);
    n_vec++; if (eop_cnt !== 0) begin n_err++; $display("[TB] FAIL reset_no_eop: got %0d, expected 0", eop_cnt); end
    n_vec++; if (err_cnt !== 0) begin n_err++; $display("[TB] FAIL reset_no_err: got %0d, expected 0", err_cnt); end
  endtask

  task automatic test_sync();
    logic [7:0] exp_bits;
    int k_cyc;
    exp_bits = 8'b0000_0001;
    clear_mon();
    drive(LJ, 8);
    k_cyc = cyc;
    send_sync(8, 8);
    drive(LSE0, 16);
    drive(LJ, 8);
    n_vec++; if (strobe_q.size() !== 8) begin n_err++; $display("[TB] FAIL sync_count: got %0d, expected 8", strobe_q.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < strobe_q.size()) begin
        n_vec++;
        if (strobe_q[i] !== exp_bits[7-i]) begin n_err++; $display("[TB] FAIL sync_bit%0d: got %b, expected %b", i, strobe_q[i], exp_bits[7-i]); end
      end
    end
    if (strobe_cyc.size() > 0) begin
      n_vec++;
      if (strobe_cyc[0] - k_cyc !== 4) begin n_err++; $display("[TB] FAIL sync_latency: got %0d, expected 4", strobe_cyc[0] - k_cyc); end
    end
  endtask

  task automatic test_eop();
    clear_mon();
    drive(LJ, 8);
    send_sync(8, 8);
    drive(LSE0, 16);
    n_vec++; if (strobe_q.size() !== 8) begin n_err++; $display("[TB] FAIL eop_no_strobe_se0: got %0d, expected 8", strobe_q.size()); end
    n_vec++; if (eop_cnt !== 0) begin n_err++; $display("[TB] FAIL eop_early: got %0d, expected 0", eop_cnt); end
    drive(LJ, 1);
    n_vec++; if (eop !== 1'b1) begin n_err++; $display("[TB] FAIL eop_first_j: got %b, expected 1", eop); end
    n_vec++; if (rx_err !== 1'b0) begin n_err++; $display("[TB] FAIL eop_no_err: got %b, expected 0", rx_err); end
    drive(LJ, 1);
    n_vec++; if (eop !== 1'b0) begin n_err++; $display("[TB] FAIL eop_clears: got %b, expected 0", eop); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL eop_idle: got %b, expected 1", idle); end
    drive(LJ, 8);
    n_vec++; if (eop_cnt !== 1) begin n_err++; $display("[TB] FAIL eop_count: got %0d, expected 1", eop_cnt); end
  endtask

  task automatic test_stuffing();
    logic [13:0] exp_bits;
    exp_bits = 14'b0_111111_111111_0;
    clear_mon();
    drive(LJ, 8);
    drive(LK, 56);
    drive(LJ, 8);
    drive(LJ, 48);
    drive(LK, 8);
    drive(LJ, 8);
    drive(LSE0, 16);
    drive(LJ, 8);
    n_vec++; if (strobe_q.size() !== 14) begin n_err++; $display("[TB] FAIL stuff_count: got %0d, expected 14", strobe_q.size()); end
    for (int i = 0; i < 14; i++) begin
      if (i < strobe_q.size()) begin
        n_vec++;
        if (strobe_q[i] !== exp_bits[13-i]) begin n_err++; $display("[TB] FAIL stuff_bit%0d: got %b, expected %b", i, strobe_q[i], exp_bits[13-i]); end
      end
    end
    n_vec++; if (err_cnt !== 0) begin n_err++; $display("[TB] FAIL stuff_no_err: got %0d, expected 0", err_cnt); end
    n_vec++; if (eop_cnt !== 1) begin n_err++; $display("[TB] FAIL stuff_eop: got %0d, expected 1", eop_cnt); end
  endtask

  task automatic test_stuff_violation();
    clear_mon();
    drive(LJ, 8);
    drive(LK, 64);
    drive(LJ, 8);
    drive(LK, 8);
    drive(LJ, 8);
    n_vec++; if (err_cnt !== 1) begin n_err++; $display("[TB] FAIL viol_err_pulse: got %0d, expected 1", err_cnt); end
    n_vec++; if (strobe_q.size() !== 7) begin n_err++; $display("[TB] FAIL viol_count: got %0d, expected 7", strobe_q.size()); end
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("[TB] FAIL viol_stays_err_on_j: idle %b, expected 0", idle); end
    drive(LSE0, 16);
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("[TB] FAIL viol_stays_err_on_se0: idle %b, expected 0", idle); end
    drive(LJ, 8);
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL viol_exit_idle: got %b, expected 1", idle); end
    n_vec++; if (eop_cnt !== 0) begin n_err++; $display("[TB] FAIL viol_no_eop: got %0d, expected 0", eop_cnt); end
    n_vec++; if (strobe_q.size() !== 7) begin n_err++; $display("[TB] FAIL viol_no_more_strobes: got %0d, expected 7", strobe_q.size()); end
  endtask

  task automatic test_jitter();
    logic [10:0] exp_bits;
    exp_bits = 11'b0000000_1010;
    clear_mon();
    drive(LJ, 8);
    send_sync(7, 9);
    drive(LJ, 7);
    drive(LJ, 9);
    drive(LK, 7);
    drive(LSE0, 16);
    drive(LJ, 8);
    n_vec++; if (strobe_q.size() !== 11) begin n_err++; $display("[TB] FAIL jitter_count: got %0d, expected 11", strobe_q.size()); end
    for (int i = 0; i < 11; i++) begin
      if (i < strobe_q.size()) begin
        n_vec++;
        if (strobe_q[i] !== exp_bits[10-i]) begin n_err++; $display("[TB] FAIL jitter_bit%0d: got %b, expected %b", i, strobe_q[i], exp_bits[10-i]); end
      end
    end
    n_vec++; if (eop_cnt !== 1) begin n_err++; $display("[TB] FAIL jitter_eop: got %0d, expected 1", eop_cnt); end
    n_vec++; if (err_cnt !== 0) begin n_err++; $display("[TB] FAIL jitter_no_err: got %0d, expected 0", err_cnt); end
  endtask

  task automatic test_enable_drop();
    logic [7:0] exp_bits;
    exp_bits = 8'b0000_0001;
    clear_mon();
    drive(LJ, 8);
    drive(LK, 8);
    drive(LJ, 8);
    drive(LK, 8);
    drive(LJ, 4);
    enable = 1'b0;
    drive(LJ, 1);
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL drop_idle: got %b, expected 1", idle); end
    n_vec++; if (shift_enable !== 1'b0) begin n_err++; $display("[TB] FAIL drop_shift: got %b, expected 0", shift_enable); end
    enable = 1'b1;
    drive(LJ, 16);
    n_vec++; if (strobe_q.size() !== 4) begin n_err++; $display("[TB] FAIL drop_count: got %0d, expected 4", strobe_q.size()); end
    n_vec++; if (eop_cnt !== 0) begin n_err++; $display("[TB] FAIL drop_no_eop: got %0d, expected 0", eop_cnt); end
    n_vec++; if (err_cnt !== 0) begin n_err++; $display("[TB] FAIL drop_no_err: got %0d, expected 0", err_cnt); end

    clear_mon();
    send_sync(8, 8);
    drive(LSE0, 16);
    drive(LJ, 8);
    n_vec++; if (strobe_q.size() !== 8) begin n_err++; $display("[TB] FAIL restart_count: got %0d, expected 8", strobe_q.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < strobe_q.size()) begin
        n_vec++;
        if (strobe_q[i] !== exp_bits[7-i]) begin n_err++; $display("[TB] FAIL restart_bit%0d: got %b, expected %b", i, strobe_q[i], exp_bits[7-i]); end
      end
    end
    n_vec++; if (eop_cnt !== 1) begin n_err++; $display("[TB] FAIL restart_eop: got %0d, expected 1", eop_cnt); end
  endtask

  initial begin
    n_rst        = 1'b0;
    enable       = 1'b1;
    d_plus_sync  = 1'b1;
    d_minus_sync = 1'b0;
    test_reset();
    test_sync();
    test_eop();
    test_stuffing();
    test_stuff_violation();
    test_jitter();
    test_enable_drop();
    n_vec++; if (both_cnt !== 0) begin n_err++; $display("[TB] FAIL eop_and_err_together: got %0d cycles, expected 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
